// File: rtl/fifo_reader_if.sv
// fifo_reader_if -- groups the FIFO read port and the downstream valid/ready
// port of fifo_reader.
//   FIFO side      : Fifo_empty, almost_empty, Fifo_Data_out, valid_read (to reader),
//                    Fifo_rd (from reader)
//   Downstream side: data_out, data_valid (from reader), data_ready (to reader)
// modport master = the reader, modport slave = the FIFO + consumer environment.
interface fifo_reader_if #(
  parameter int BITNUMBER = 6
);
  logic                 Fifo_empty;
  logic                 almost_empty;
  logic [BITNUMBER-1:0] Fifo_Data_out;
  logic                 valid_read;
  logic                 Fifo_rd;
  logic [BITNUMBER-1:0] data_out;
  logic                 data_valid;
  logic                 data_ready;

  modport master (
    input  Fifo_empty, almost_empty, Fifo_Data_out, valid_read, data_ready,
    output Fifo_rd, data_out, data_valid
  );

  modport slave (
    output Fifo_empty, almost_empty, Fifo_Data_out, valid_read, data_ready,
    input  Fifo_rd, data_out, data_valid
  );
endinterface

// File: rtl/fifo_reader.sv
// fifo_reader -- drains a 1-cycle-latency FIFO into a valid/ready stream
// through a 2-entry skid buffer.
//   clk, reset : clock, asynchronous active-high reset
//   enable     : 1 = drain the FIFO, 0 = finish in-flight work and go idle
//   bus        : fifo_reader_if.master (FIFO read port + downstream port)
//   busy       : FSM is not IDLE
//   word_count : words handed downstream (wraps)
//   rd_error   : sticky, set by a valid_read with no read outstanding
module fifo_reader #(
  parameter int BITNUMBER = 6,
  parameter int CNTWIDTH  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  fifo_reader_if.master       bus,
  output logic                busy,
  output logic [CNTWIDTH-1:0] word_count,
  output logic                rd_error
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t               state, state_nxt;
  logic [BITNUMBER-1:0] sbuf [2];
  logic                 wr_ptr, rd_ptr;
  logic [1:0]           occ;
  logic                 in_flight;   // Fifo_rd issued last cycle, word arrives now
  logic                 last_pop;    // last cycle popped the final FIFO word
  logic                 fresh;       // first cycle after reset release
  logic                 xfer, cap, bad;
  logic [1:0]           slots;

  assign xfer = (occ != 2'd0) && bus.data_ready;
  assign cap  = bus.valid_read && in_flight;
  // A stray valid_read right after reset belongs to a read that reset
  // discarded, so it is neither captured nor flagged.
  assign bad  = bus.valid_read && !in_flight && !fresh;

  // Occupancy counted after this cycle's transfer leaves, so a word can be
  // requested every cycle while the consumer keeps up.
  assign slots = occ - 2'(xfer) + 2'(in_flight);

  assign bus.Fifo_rd    = (state == RUN) && !bus.Fifo_empty && !last_pop && (slots < 2'd2);
  assign bus.data_valid = (occ != 2'd0);
  assign bus.data_out   = sbuf[rd_ptr];

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (!enable) state_nxt = FLUSH;
      FLUSH: begin
        if (enable)                            state_nxt = RUN;
        else if (!in_flight && occ == 2'd0)    state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sbuf[0]    <= '0;
      sbuf[1]    <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      occ        <= 2'd0;
      in_flight  <= 1'b0;
      last_pop   <= 1'b0;
      fresh      <= 1'b1;
      word_count <= '0;
      rd_error   <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_flight <= bus.Fifo_rd;
      last_pop  <= bus.Fifo_rd && bus.almost_empty;
      fresh     <= 1'b0;
      if (bad) rd_error <= 1'b1;
      if (cap) begin
        sbuf[wr_ptr] <= bus.Fifo_Data_out;
        wr_ptr       <= ~wr_ptr;
      end
      if (xfer) begin
        rd_ptr     <= ~rd_ptr;
        word_count <= word_count + CNTWIDTH'(1);
      end
      occ <= occ + 2'(cap) - 2'(xfer);
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
module tb_fifo_reader;
  localparam int BW = 6;
  localparam int CW = 4;

  logic          clk, reset, enable;
  logic          busy, rd_error;
  logic [CW-1:0] word_count;

  fifo_reader_if #(.BITNUMBER(BW)) bus ();

  fifo_reader #(.BITNUMBER(BW), .CNTWIDTH(CW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .bus(bus),
    .busy(busy), .word_count(word_count), .rd_error(rd_error)
  );

  // FIFO + consumer environment
  logic [BW-1:0] fq [$];
  logic [BW-1:0] exp_q [$];     // words popped from the FIFO, not yet delivered
  int            fcnt = 0;
  int            rd_cnt = 0;
  logic          vr = 0, inject = 0, ready = 0;
  logic          push_v = 0, fifo_clr = 0;
  logic [BW-1:0] push_d = '0, rdata = '0, popw;
  logic          force_flags = 0, f_empty = 0, f_ae = 0;

  int nchk = 0, nerr = 0;

  assign bus.Fifo_empty    = force_flags ? f_empty : (fcnt == 0);
  assign bus.almost_empty  = force_flags ? f_ae    : (fcnt == 1);
  assign bus.valid_read    = vr | inject;
  assign bus.Fifo_Data_out = rdata;
  assign bus.data_ready    = ready;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // One-cycle-latency FIFO model
  always @(posedge clk) begin
    if (fifo_clr) begin
      fq.delete();
      vr <= 1'b0;
    end else begin
      vr <= 1'b0;
      if (bus.Fifo_rd) begin
        rd_cnt <= rd_cnt + 1;
        if (fq.size() > 0) begin
          popw = fq.pop_front();
          rdata <= popw;
          vr    <= 1'b1;
          exp_q.push_back(popw);
        end
      end
      if (push_v) fq.push_back(push_d);
    end
    fcnt <= fifo_clr ? 0 : fq.size();
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Stream monitor: order, count, hold stability, read legality
  int            wc_model = 0;
  logic          hold = 0;
  logic [BW-1:0] hold_d = '0;
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      wc_model = 0;
      hold     = 0;
    end else begin
      chk("word_count", 32'(word_count), 32'(wc_model % (1 << CW)));
      if (hold) begin
        chk("hold_valid", 32'(bus.data_valid), 32'd1);
        chk("hold_data", 32'(bus.data_out), 32'(hold_d));
      end
      if (bus.Fifo_rd) chk("rd_when_empty", 32'(bus.Fifo_empty), 32'd0);
      chk("pending_le2", 32'(exp_q.size() <= 2), 32'd1);
      if (bus.data_valid) begin
        chk("valid_has_word", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0 && ready) begin
          chk("xfer_data", 32'(bus.data_out), 32'(exp_q[0]));
          void'(exp_q.pop_front());
          wc_model++;
        end
      end
      hold   = bus.data_valid && !ready;
      hold_d = bus.data_out;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [BW-1:0] w);
    push_v = 1; push_d = w;
    cyc();
    push_v = 0;
  endtask

  task automatic do_reset();
    enable = 0; ready = 0; inject = 0; reset = 1; fifo_clr = 1;
    cyc(); cyc();
    reset = 0; fifo_clr = 0;
    cyc();
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_rd"},    32'(bus.Fifo_rd), 32'd0);
    chk({pfx, "_valid"}, 32'(bus.data_valid), 32'd0);
    chk({pfx, "_busy"},  32'(busy), 32'd0);
    chk({pfx, "_wc"},    32'(word_count), 32'd0);
    chk({pfx, "_err"},   32'(rd_error), 32'd0);
    chk({pfx, "_data"},  32'(bus.data_out), 32'd0);
  endtask

  logic [7:0] rdpat, xfpat;
  int         r0;
  logic       got;

  initial begin
    reset = 1; enable = 0; fifo_clr = 1;
    #3;
    chk_reset_vals("rst0");
    cyc(); cyc();
    reset = 0; fifo_clr = 0;
    cyc();

    // Three words, consumer always ready
    push(6'h01); push(6'h02); push(6'h03);
    ready = 1; enable = 1; #1;
    for (int i = 0; i < 8; i++) begin
      rdpat[i] = bus.Fifo_rd;
      xfpat[i] = bus.data_valid && ready;
      cyc();
    end
    chk("three_rd_pattern", 32'(rdpat), 32'h0e);
    chk("three_xfer_pattern", 32'(xfpat), 32'h38);
    chk("three_wc", 32'(word_count), 32'd3);
    chk("three_busy", 32'(busy), 32'd1);
    chk("three_rd_idle", 32'(bus.Fifo_rd), 32'd0);

    // Four words, consumer stalled
    do_reset();
    push(6'h11); push(6'h22); push(6'h33); push(6'h2c);
    r0 = rd_cnt; enable = 1;
    repeat (8) cyc();
    chk("stall_rd_pulses", 32'(rd_cnt - r0), 32'd2);
    chk("stall_valid", 32'(bus.data_valid), 32'd1);
    chk("stall_data", 32'(bus.data_out), 32'h11);
    ready = 1;
    for (int i = 0; i < 20 && word_count != 4'd4; i++) cyc();
    chk("stall_wc", 32'(word_count), 32'd4);
    cyc(); cyc();
    chk("stall_drained", 32'(bus.data_valid), 32'd0);

    // Single word with almost_empty, flags reporting one cycle late
    do_reset();
    push(6'h15);
    r0 = rd_cnt; enable = 1; #1;
    got = 0;
    for (int i = 0; i < 5 && !got; i++) begin
      if (bus.Fifo_rd) got = 1; else cyc();
    end
    chk("last_rd_seen", 32'(got), 32'd1);
    cyc();
    force_flags = 1; f_empty = 0; f_ae = 1; #1;
    chk("last_no_rd_after", 32'(bus.Fifo_rd), 32'd0);
    cyc();
    force_flags = 0;
    ready = 1;
    cyc(); cyc(); cyc();
    chk("last_rd_pulses", 32'(rd_cnt - r0), 32'd1);
    chk("last_err", 32'(rd_error), 32'd0);
    chk("last_wc", 32'(word_count), 32'd1);

    // Stray valid_read while idle
    do_reset();
    cyc();
    inject = 1; cyc(); inject = 0; #1;
    chk("stray_err", 32'(rd_error), 32'd1);
    chk("stray_valid", 32'(bus.data_valid), 32'd0);
    cyc();
    chk("stray_err_sticky", 32'(rd_error), 32'd1);
    chk("stray_valid2", 32'(bus.data_valid), 32'd0);

    // Drop enable with one read in flight
    do_reset();
    ready = 1;
    push(6'h2a);
    enable = 1; #1;
    got = 0;
    for (int i = 0; i < 5 && !got; i++) begin
      if (bus.Fifo_rd) got = 1; else cyc();
    end
    chk("flush_rd_seen", 32'(got), 32'd1);
    cyc();
    enable = 0; #1;
    chk("flush_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 10 && busy; i++) cyc();
    chk("flush_idle", 32'(busy), 32'd0);
    chk("flush_wc", 32'(word_count), 32'd1);
    chk("flush_valid", 32'(bus.data_valid), 32'd0);

    // Async reset with a full buffer, then stray valid_read right after release
    ready = 0;
    push(6'h07); push(6'h08); push(6'h09);
    enable = 1;
    repeat (5) cyc();
    chk("full_valid", 32'(bus.data_valid), 32'd1);
    chk("full_data", 32'(bus.data_out), 32'h07);
    #2 reset = 1; #1;
    chk_reset_vals("async_rst");
    enable = 0; fifo_clr = 1;
    cyc();
    reset = 0; fifo_clr = 0; inject = 1;
    cyc();
    inject = 0; #1;
    chk("post_rst_err", 32'(rd_error), 32'd0);
    chk("post_rst_valid", 32'(bus.data_valid), 32'd0);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      push_v = ($urandom_range(0, 1) == 0);
      push_d = BW'($urandom);
      ready  = ($urandom_range(0, 3) != 0);
      enable = ($urandom_range(0, 7) != 0);
      cyc();
    end
    push_v = 0; enable = 1; ready = 1;
    for (int i = 0; i < 600 && (fcnt != 0 || exp_q.size() != 0); i++) cyc();
    chk("rand_drained", 32'(exp_q.size()), 32'd0);
    enable = 0;
    for (int i = 0; i < 10 && busy; i++) cyc();
    chk("rand_idle", 32'(busy), 32'd0);
    chk("rand_err", 32'(rd_error), 32'd0);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter BITNUMBER, default 6, data word width in bits.
REQ-002 Parameter CNTWIDTH, default 8, width of the delivered-word counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  high allows draining the FIFO; low requests a clean stop.
REQ-006 Fifo_empty  input  1  FIFO holds no words.
REQ-007 almost_empty  input  1  FIFO holds exactly one word.
REQ-008 Fifo_Data_out  input  BITNUMBER  read data from the FIFO, valid when valid_read is high.
REQ-009 valid_read  input  1  FIFO returns a word this cycle, one cycle after Fifo_rd.
REQ-010 data_ready  input  1  downstream accepts data_out this cycle.
REQ-011 Fifo_rd  output  1  pop request to the FIFO.
REQ-012 data_out  output  BITNUMBER  word presented downstream.
REQ-013 data_valid  output  1  data_out holds a valid word.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 word_count  output  CNTWIDTH  number of words delivered downstream.
REQ-016 rd_error  output  1  sticky flag for a protocol violation on the read side.

Function
REQ-017 FSM states are IDLE, RUN and FLUSH; IDLE->RUN when enable=1; RUN->FLUSH when enable=0; FLUSH->IDLE when no read is in flight and the buffer is empty; FLUSH->RUN when enable=1.
REQ-018 The block SHALL hold a 2-entry skid buffer, ordered FIFO, with an occupancy count of 0..2.
REQ-019 Fifo_rd SHALL be asserted only in RUN, only when Fifo_empty=0, and only when buffer occupancy plus in-flight reads is less than 2.
REQ-020 Fifo_rd SHALL NOT be asserted in a cycle following a Fifo_rd issued while almost_empty=1, because the last word is already being popped.
REQ-021 Read latency is fixed: Fifo_rd in cycle N -> valid_read and Fifo_Data_out in cycle N+1; the word SHALL be written into the buffer at the end of cycle N+1.
REQ-022 data_valid SHALL be high whenever occupancy>0, and data_out SHALL be the oldest buffered word.
REQ-023 Transfer occurs when data_valid=1 and data_ready=1; the oldest entry is removed and word_count increments at that edge.
REQ-024 A simultaneous buffer write and transfer SHALL leave occupancy unchanged and preserve order.
REQ-025 word_count SHALL wrap from 2^CNTWIDTH-1 to 0 with no other effect.
REQ-026 data_out SHALL remain stable while data_valid=1 and data_ready=0.
REQ-027 valid_read=1 with no read in flight SHALL set rd_error and drop the word; rd_error clears only on reset.
REQ-028 In FLUSH, no new Fifo_rd is issued; in-flight words are still captured and delivered.
REQ-029 Throughput with data_ready held at 1 and the FIFO non-empty SHALL be one word per cycle after the first.

Reset
REQ-030 While reset=1, regardless of clk: state is IDLE, occupancy and in-flight are 0, and Fifo_rd=0, data_valid=0, busy=0, word_count=0, rd_error=0, data_out=0.
REQ-031 A reset asserted mid-transfer SHALL discard buffered and in-flight words; a valid_read arriving in the first cycle after release SHALL be ignored and SHALL NOT set rd_error.

Verification
REQ-032 FIFO preloaded with 0x01,0x02,0x03, enable=1, data_ready=1 -> Fifo_rd high for three cycles; data_out delivers 0x01,0x02,0x03 on consecutive cycles; word_count=3; state returns to RUN with Fifo_rd=0.
REQ-033 Four words, data_ready=0 -> exactly two Fifo_rd pulses, occupancy 2, data_out stable at the first word; data_ready=1 then drains all four in order.
REQ-034 Exactly one word with almost_empty=1 -> a single Fifo_rd pulse and no read on the following cycle; rd_error stays 0.
REQ-035 Inject valid_read=1 while idle -> rd_error=1 and data_valid stays 0.
REQ-036 Drop enable with one read in flight and data_ready=1 -> FLUSH, the word is delivered, then IDLE with busy=0.
REQ-037 Pulse reset with occupancy 2 -> all outputs return to their reset values immediately, without waiting for a clk edge.
